cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Control FSM for the 2-way set-associative cache. It sequences the per-way data, tag, valid and dirty register arrays and the shared LRU array. It also arbitrates cache-side accesses against physical-memory writeback and line fill, and clears all metadata arrays after reset. It sits between the CPU-side request port and the physical-memory port, alongside the cache datapath that holds the arrays and hit comparators.

## Interface
- S_INDEX, 3, set-index width; 2**S_INDEX sets
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp; never asserted together with mem_read
- set_idx  in  S_INDEX  set index of the current CPU address
- hit  in  2  per-way tag-match AND valid, combinational from datapath
- valid  in  2  valid bits of set_idx, per way
- dirty  in  2  dirty bits of set_idx, per way
- lru  in  1  LRU array output for set_idx; value is the victim way
- pmem_resp  in  1  physical-memory completion, one-cycle pulse
- arr_index  out  S_INDEX  write index to all arrays
- data_load  out  2  per-way data array load
- data_sel  out  1  0 = CPU write data, 1 = pmem line
- tag_load  out  2  per-way tag array load
- valid_load  out  2  per-way valid array load
- valid_in  out  1  valid write value
- dirty_load  out  2  per-way dirty array load
- dirty_in  out  1  dirty write value
- lru_load  out  1  LRU array load
- lru_in  out  1  LRU write value
- wb_addr_sel  out  1  1 = pmem address built from victim tag
- pmem_read  out  1  line-fill request, level, held until pmem_resp
- pmem_write  out  1  writeback request, level, held until pmem_resp
- mem_resp  out  1  CPU completion, one-cycle pulse
- busy  out  1  high in INIT, WB and ALLOC

## Operation
- States:
  - INIT (reset state): arr_index = init counter. Assert valid_load = dirty_load = 2'b11, lru_load = 1, with valid_in = dirty_in = lru_in = 0. Counter increments every cycle. Go to IDLE when the counter = 2**S_INDEX-1.
  - IDLE: arr_index = set_idx.
    - Read hit: mem_resp = 1. lru_load = 1 with lru_in = ~hit way. Stay in IDLE.
    - Write hit: additionally data_load[hit way] = 1, data_sel = 0, dirty_load[hit way] = 1, dirty_in = 1.
    - Miss: victim v = lru. Go to WB if valid[v] & dirty[v], else go to ALLOC. No array load on a miss.
  - WB: pmem_write = 1, wb_addr_sel = 1. On pmem_resp go to ALLOC.
  - ALLOC: pmem_read = 1. On pmem_resp:
    - data_load[v], tag_load[v], valid_load[v] = 1, valid_in = 1, data_sel = 1.
    - dirty_load[v] = 1, dirty_in = 0.
    - Go to IDLE.
  - After ALLOC, IDLE re-evaluates and hits, so every miss completes through the hit path.
- Victim v is registered on IDLE→WB/ALLOC and held to completion. It does not follow lru.
- hit = 2'b11 is illegal; way 0 takes priority.
- Requests dropped mid-miss: the fill still completes, with no mem_resp.
- All unlisted outputs are 0 in every state.

## Timing
- While rst = 0: state = INIT, counter = 0, and every output is 0, including load strobes and busy. pmem strobes drop asynchronously.
- Release of rst: INIT lasts exactly 2**S_INDEX cycles. busy = 1 throughout. CPU requests are ignored (no mem_resp).
- Hit latency: mem_resp in the same cycle the request is sampled in IDLE. Back-to-back hits are allowed every cycle.
- Clean miss: 1 IDLE + N ALLOC cycles (N = cycles to pmem_resp) + 1 IDLE hit.
- Dirty miss: additionally M WB cycles.
- pmem_resp arriving in the same cycle the request is raised is legal.
- Reset mid-WB/ALLOC aborts the transfer and restarts INIT.
- The arrays forward same-cycle writes, so data written on a load cycle is visible on the next read.

## Structure
- Shared package cache_pkg:
  - state enum (INIT, IDLE, WB, ALLOC)
  - DATA_SEL_CPU / DATA_SEL_PMEM constants
  - S_INDEX default
- Single module. No sub-module: the init counter and victim register are inline.

## Test plan
- Reset release with S_INDEX=3 → busy high exactly 8 cycles; arr_index steps 0..7; valid/dirty/lru loads every cycle with values 0; then IDLE.
- Read to set 5 with hit = 2'b10 → same-cycle mem_resp, lru_load = 1, lru_in = 0, no data_load.
- Write to set 2 with hit = 2'b01 → mem_resp, data_load = 2'b01, dirty_load = 2'b01, dirty_in = 1, lru_in = 1.
- Miss with lru = 1, valid = 2'b10, dirty = 2'b10 → WB (pmem_write, wb_addr_sel) until pmem_resp at +3; then ALLOC; pmem_resp at +4 → data/tag/valid_load = 2'b10, dirty_in = 0; then hit mem_resp.
- Clean miss with lru flipped to 0 during ALLOC → loads still target way 1 (registered victim).
- rst asserted during ALLOC → pmem_read drops immediately; INIT reruns in full after release.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the 2-way set-associative cache controller.
package cache_pkg;

  localparam int S_INDEX_DEF = 3;

  localparam logic DATA_SEL_CPU  = 1'b0;
  localparam logic DATA_SEL_PMEM = 1'b1;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    WB    = 2'd2,
    ALLOC = 2'd3
  } state_e;

  function automatic logic [1:0] way_mask(input logic way);
    return way ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/cache_ctrl.sv
// Control FSM for the 2-way set-associative cache: metadata clear after reset,
// hit handling, dirty-victim writeback and line fill.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int S_INDEX = S_INDEX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [S_INDEX-1:0] set_idx,
  input  logic [1:0]         hit,
  input  logic [1:0]         valid,
  input  logic [1:0]         dirty,
  input  logic               lru,
  input  logic               pmem_resp,
  output logic [S_INDEX-1:0] arr_index,
  output logic [1:0]         data_load,
  output logic               data_sel,
  output logic [1:0]         tag_load,
  output logic [1:0]         valid_load,
  output logic               valid_in,
  output logic [1:0]         dirty_load,
  output logic               dirty_in,
  output logic               lru_load,
  output logic               lru_in,
  output logic               wb_addr_sel,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic               mem_resp,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [S_INDEX-1:0] cnt_q, cnt_d;
  logic               victim_q, victim_d;

  logic req;
  logic hit_way;

  assign req     = mem_read | mem_write;
  // hit = 2'b11 cannot happen legally; way 0 wins if it does.
  assign hit_way = ~hit[0];

  always_comb begin
    // NOTE: every output and next-state signal gets a default here so no path
    // through the case statement can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    victim_d    = victim_q;
    arr_index   = '0;
    data_load   = 2'b00;
    data_sel    = DATA_SEL_CPU;
    tag_load    = 2'b00;
    valid_load  = 2'b00;
    valid_in    = 1'b0;
    dirty_load  = 2'b00;
    dirty_in    = 1'b0;
    lru_load    = 1'b0;
    lru_in      = 1'b0;
    wb_addr_sel = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    mem_resp    = 1'b0;
    busy        = 1'b0;

    // NOTE: outputs are gated by rst directly so pmem strobes and load enables
    // fall as soon as reset asserts, not at the next clock edge.
    if (rst) begin
      unique case (state_q)
        INIT: begin
          arr_index  = cnt_q;
          valid_load = 2'b11;
          dirty_load = 2'b11;
          lru_load   = 1'b1;
          busy       = 1'b1;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == '1) state_d = IDLE;
        end

        IDLE: begin
          arr_index = set_idx;
          if (req) begin
            if (|hit) begin
              mem_resp = 1'b1;
              lru_load = 1'b1;
              lru_in   = ~hit_way;
              if (mem_write) begin
                data_load  = way_mask(hit_way);
                data_sel   = DATA_SEL_CPU;
                dirty_load = way_mask(hit_way);
                dirty_in   = 1'b1;
              end
            end else begin
              victim_d = lru;
              state_d  = (valid[lru] & dirty[lru]) ? WB : ALLOC;
            end
          end
        end

        WB: begin
          arr_index   = set_idx;
          pmem_write  = 1'b1;
          wb_addr_sel = 1'b1;
          busy        = 1'b1;
          if (pmem_resp) state_d = ALLOC;
        end

        ALLOC: begin
          arr_index = set_idx;
          pmem_read = 1'b1;
          busy      = 1'b1;
          // The fill lands in the victim captured at miss time, not the live lru.
          if (pmem_resp) begin
            data_load  = way_mask(victim_q);
            tag_load   = way_mask(victim_q);
            valid_load = way_mask(victim_q);
            valid_in   = 1'b1;
            data_sel   = DATA_SEL_PMEM;
            dirty_load = way_mask(victim_q);
            dirty_in   = 1'b0;
            state_d    = IDLE;
          end
        end

        default: state_d = INIT;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      victim_q <= victim_d;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: each driven cycle pushes its expected
// outputs, and a negedge monitor pops and compares them.
module tb_cache_ctrl;
  import cache_pkg::*;

  localparam int SI = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_read, mem_write;
  logic [SI-1:0] set_idx;
  logic [1:0]    hit, valid, dirty;
  logic          lru, pmem_resp;
  logic [SI-1:0] arr_index;
  logic [1:0]    data_load, tag_load, valid_load, dirty_load;
  logic          data_sel, valid_in, dirty_in, lru_load, lru_in;
  logic          wb_addr_sel, pmem_read, pmem_write, mem_resp, busy;

  cache_ctrl #(.S_INDEX(SI)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .set_idx    (set_idx),
    .hit        (hit),
    .valid      (valid),
    .dirty      (dirty),
    .lru        (lru),
    .pmem_resp  (pmem_resp),
    .arr_index  (arr_index),
    .data_load  (data_load),
    .data_sel   (data_sel),
    .tag_load   (tag_load),
    .valid_load (valid_load),
    .valid_in   (valid_in),
    .dirty_load (dirty_load),
    .dirty_in   (dirty_in),
    .lru_load   (lru_load),
    .lru_in     (lru_in),
    .wb_addr_sel(wb_addr_sel),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .mem_resp   (mem_resp),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [SI-1:0] arr_index;
    logic [1:0]    data_load, tag_load, valid_load, dirty_load;
    logic          data_sel, valid_in, dirty_in, lru_load, lru_in;
    logic          wb_addr_sel, pmem_read, pmem_write, mem_resp, busy;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".arr_index"},   32'(arr_index),   32'(e.arr_index));
      check({e.name, ".data_load"},   32'(data_load),   32'(e.data_load));
      check({e.name, ".data_sel"},    32'(data_sel),    32'(e.data_sel));
      check({e.name, ".tag_load"},    32'(tag_load),    32'(e.tag_load));
      check({e.name, ".valid_load"},  32'(valid_load),  32'(e.valid_load));
      check({e.name, ".valid_in"},    32'(valid_in),    32'(e.valid_in));
      check({e.name, ".dirty_load"},  32'(dirty_load),  32'(e.dirty_load));
      check({e.name, ".dirty_in"},    32'(dirty_in),    32'(e.dirty_in));
      check({e.name, ".lru_load"},    32'(lru_load),    32'(e.lru_load));
      check({e.name, ".lru_in"},      32'(lru_in),      32'(e.lru_in));
      check({e.name, ".wb_addr_sel"}, 32'(wb_addr_sel), 32'(e.wb_addr_sel));
      check({e.name, ".pmem_read"},   32'(pmem_read),   32'(e.pmem_read));
      check({e.name, ".pmem_write"},  32'(pmem_write),  32'(e.pmem_write));
      check({e.name, ".mem_resp"},    32'(mem_resp),    32'(e.mem_resp));
      check({e.name, ".busy"},        32'(busy),        32'(e.busy));
    end
  end

  function automatic exp_t blank(input string n, input logic [SI-1:0] idx, input logic bsy);
    exp_t e;
    e.name = n;        e.arr_index = idx;
    e.data_load = '0;  e.tag_load = '0;    e.valid_load = '0; e.dirty_load = '0;
    e.data_sel = 1'b0; e.valid_in = 1'b0;  e.dirty_in = 1'b0;
    e.lru_load = 1'b0; e.lru_in = 1'b0;    e.wb_addr_sel = 1'b0;
    e.pmem_read = 1'b0; e.pmem_write = 1'b0; e.mem_resp = 1'b0; e.busy = bsy;
    return e;
  endfunction

  function automatic exp_t fill(input string n, input logic [SI-1:0] idx, input logic [1:0] w);
    exp_t e;
    e = blank(n, idx, 1'b1);
    e.pmem_read = 1'b1;
    e.data_load = w; e.tag_load = w; e.valid_load = w; e.dirty_load = w;
    e.valid_in = 1'b1; e.data_sel = 1'b1; e.dirty_in = 1'b0;
    return e;
  endfunction

  function automatic exp_t rd_hit(input string n, input logic [SI-1:0] idx, input logic new_lru);
    exp_t e;
    e = blank(n, idx, 1'b0);
    e.mem_resp = 1'b1; e.lru_load = 1'b1; e.lru_in = new_lru;
    return e;
  endfunction

  task automatic step(input exp_t e);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_init(input string n);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e = blank($sformatf("%s%0d", n, i), SI'(i), 1'b1);
      e.valid_load = 2'b11; e.dirty_load = 2'b11; e.lru_load = 1'b1;
      step(e);
    end
  endtask

  task automatic idle_req(input logic rd, input logic wr, input logic [SI-1:0] idx,
                          input logic [1:0] h);
    mem_read = rd; mem_write = wr; set_idx = idx; hit = h;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    exp_t e;
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; set_idx = '0; hit = '0;
    valid = '0; dirty = '0; lru = 1'b0; pmem_resp = 1'b0;
    @(posedge clk);
    #1;

    // In reset: everything low, requests ignored.
    idle_req(1'b1, 1'b0, 3'd5, 2'b01);
    step(blank("rst0", '0, 1'b0));
    step(blank("rst1", '0, 1'b0));

    // Release: 8 INIT cycles, CPU request held but never answered.
    rst = 1'b1;
    run_init("init");

    idle_req(1'b1, 1'b0, 3'd5, 2'b10);
    step(rd_hit("rdhit5", 3'd5, 1'b0));
    idle_req(1'b0, 1'b0, 3'd1, 2'b00);
    step(blank("idle1", 3'd1, 1'b0));

    // Write hit way 0, then back-to-back illegal 11 hit resolves to way 0.
    idle_req(1'b0, 1'b1, 3'd2, 2'b01);
    e = rd_hit("wrhit2", 3'd2, 1'b1);
    e.data_load = 2'b01; e.dirty_load = 2'b01; e.dirty_in = 1'b1;
    step(e);
    idle_req(1'b1, 1'b0, 3'd3, 2'b11);
    step(rd_hit("hit11", 3'd3, 1'b1));

    // Dirty miss: victim way 1 valid+dirty -> WB 3 cycles, ALLOC 4 cycles.
    idle_req(1'b1, 1'b0, 3'd4, 2'b00);
    lru = 1'b1; valid = 2'b10; dirty = 2'b10;
    step(blank("dmiss", 3'd4, 1'b0));
    for (int j = 0; j < 3; j++) begin
      pmem_resp = (j == 2);
      e = blank($sformatf("wb%0d", j), 3'd4, 1'b1);
      e.pmem_write = 1'b1; e.wb_addr_sel = 1'b1;
      step(e);
    end
    for (int k = 0; k < 4; k++) begin
      pmem_resp = (k == 3);
      if (k == 3) e = fill("dfill", 3'd4, 2'b10);
      else begin
        e = blank($sformatf("dalloc%0d", k), 3'd4, 1'b1);
        e.pmem_read = 1'b1;
      end
      step(e);
    end
    pmem_resp = 1'b0; hit = 2'b10;
    step(rd_hit("dhit", 3'd4, 1'b0));

    // Clean write miss; lru flips during ALLOC but the fill stays in way 1.
    idle_req(1'b0, 1'b1, 3'd6, 2'b00);
    lru = 1'b1; valid = 2'b00; dirty = 2'b00;
    step(blank("cmiss", 3'd6, 1'b0));
    lru = 1'b0;
    e = blank("calloc", 3'd6, 1'b1); e.pmem_read = 1'b1;
    step(e);
    pmem_resp = 1'b1;
    step(fill("cfill", 3'd6, 2'b10));
    pmem_resp = 1'b0; hit = 2'b10;
    e = rd_hit("cwhit", 3'd6, 1'b0);
    e.data_load = 2'b10; e.dirty_load = 2'b10; e.dirty_in = 1'b1;
    step(e);

    // pmem_resp already high when the request is raised: fill completes at once.
    idle_req(1'b1, 1'b0, 3'd7, 2'b00);
    lru = 1'b0; valid = 2'b01; dirty = 2'b00; pmem_resp = 1'b1;
    step(blank("fmiss", 3'd7, 1'b0));
    step(fill("ffill", 3'd7, 2'b01));
    pmem_resp = 1'b0; hit = 2'b01;
    step(rd_hit("fhit", 3'd7, 1'b1));

    // Request dropped mid-fill: fill still lands, no mem_resp afterwards.
    idle_req(1'b1, 1'b0, 3'd0, 2'b00);
    lru = 1'b0; valid = 2'b11; dirty = 2'b10;
    step(blank("xmiss", 3'd0, 1'b0));
    mem_read = 1'b0;
    e = blank("xalloc", 3'd0, 1'b1); e.pmem_read = 1'b1;
    step(e);
    pmem_resp = 1'b1;
    step(fill("xfill", 3'd0, 2'b01));
    pmem_resp = 1'b0; hit = 2'b01;
    step(blank("xidle", 3'd0, 1'b0));

    // Reset during ALLOC aborts the fill and reruns INIT in full.
    idle_req(1'b1, 1'b0, 3'd3, 2'b00);
    lru = 1'b1; valid = 2'b00; dirty = 2'b00;
    step(blank("rmiss", 3'd3, 1'b0));
    e = blank("ralloc", 3'd3, 1'b1); e.pmem_read = 1'b1;
    step(e);
    rst = 1'b0;
    step(blank("rabort0", '0, 1'b0));
    step(blank("rabort1", '0, 1'b0));
    rst = 1'b1; hit = 2'b10;
    run_init("reinit");
    step(rd_hit("posthit", 3'd3, 1'b0));

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
